// File: rtl/complex_nr_mult_stim_gen.sv
// Stimulus generator and checker for a complex multiplier: drives operand sets (fixed, corner, LFSR random),
// collects results over valid/ready handshakes, compares against full-precision expected values.
module complex_nr_mult_stim_gen #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          TXN_COUNT      = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] SEED           = 32'h1ACE_B00C
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  op_ready,
  input  logic                  res_val,
  input  logic [2*DATA_WIDTH:0] res_re,
  input  logic [2*DATA_WIDTH:0] res_im,
  output logic                  sw_rst,
  output logic                  op_val,
  output logic                  res_ready,
  output logic [DATA_WIDTH-1:0] op_1_re,
  output logic [DATA_WIDTH-1:0] op_1_im,
  output logic [DATA_WIDTH-1:0] op_2_re,
  output logic [DATA_WIDTH-1:0] op_2_im,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [7:0]            err_count,
  output logic [7:0]            txn_done
);
  localparam int          RW        = 2*DATA_WIDTH+1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_SWRST, S_LOAD, S_DRIVE, S_WAIT_RES, S_CHECK, S_FINISH
  } state_t;

  state_t                       r_state, w_state_next;
  logic [1:0]                   r_mode;
  logic [31:0]                  r_lfsr;
  logic [31:0]                  w_lfsr_next;
  logic [3:0][DATA_WIDTH-1:0]   r_op;
  logic [3:0][DATA_WIDTH-1:0]   w_lfsr_op;
  logic [3:0][DATA_WIDTH-1:0]   w_load_op;
  logic [RW-1:0]                w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic [RW-1:0]                r_exp_re, r_exp_im, r_res_re, r_res_im;
  logic [7:0]                   r_err_count, r_txn_done;
  logic [7:0]                   w_err_next, w_txn_next;
  logic                         r_timeout, r_pass;
  logic                         w_timeout_next, w_tmo_hit, w_tmo_fire, w_mismatch, w_err_bump;
  logic [9:0]                   r_tmo_cnt;

  // Operand index order: 0=op_1_re, 1=op_1_im, 2=op_2_re, 3=op_2_im; each takes one LFSR byte lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lfsr_slice
    assign w_lfsr_op[gi] = r_lfsr[gi*8 +: DATA_WIDTH];
  end

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);

  always_comb begin
    w_load_op = w_lfsr_op;
    case (r_mode)
      2'd0:    w_load_op = {DATA_WIDTH'(2), DATA_WIDTH'(4), DATA_WIDTH'(3), DATA_WIDTH'(2)};
      2'd2:    w_load_op = '1;
      default: w_load_op = w_lfsr_op;
    endcase
  end

  assign w_p_rr = RW'(w_load_op[0]) * RW'(w_load_op[2]);
  assign w_p_ii = RW'(w_load_op[1]) * RW'(w_load_op[3]);
  assign w_p_ri = RW'(w_load_op[0]) * RW'(w_load_op[3]);
  assign w_p_ir = RW'(w_load_op[1]) * RW'(w_load_op[2]);

  assign w_tmo_hit      = (r_tmo_cnt == 10'(TIMEOUT_CYCLES - 1));
  assign w_tmo_fire     = w_tmo_hit && (((r_state == S_DRIVE) && !op_ready) ||
                                        ((r_state == S_WAIT_RES) && !res_val));
  assign w_mismatch     = (r_res_re != r_exp_re) || (r_res_im != r_exp_im);
  assign w_err_bump     = w_tmo_fire || ((r_state == S_CHECK) && w_mismatch);
  assign w_err_next     = (w_err_bump && (r_err_count != 8'hFF)) ? r_err_count + 8'd1 : r_err_count;
  assign w_txn_next     = r_txn_done + 8'd1;
  assign w_timeout_next = r_timeout | w_tmo_fire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_next = S_SWRST;
      S_SWRST:    w_state_next = S_LOAD;
      S_LOAD:     w_state_next = S_DRIVE;
      S_DRIVE:    if (op_ready)       w_state_next = S_WAIT_RES;
                  else if (w_tmo_hit) w_state_next = S_FINISH;
      S_WAIT_RES: if (res_val)        w_state_next = S_CHECK;
                  else if (w_tmo_hit) w_state_next = S_FINISH;
      S_CHECK:    w_state_next = ((r_mode == 2'd3) && (int'(w_txn_next) < TXN_COUNT)) ? S_LOAD : S_FINISH;
      S_FINISH:   w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode      <= '0;
      r_lfsr      <= SEED;
      r_op        <= '0;
      r_exp_re    <= '0;
      r_exp_im    <= '0;
      r_res_re    <= '0;
      r_res_im    <= '0;
      r_err_count <= '0;
      r_txn_done  <= '0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mode      <= mode;
          r_err_count <= '0;
          r_txn_done  <= '0;
          r_timeout   <= 1'b0;
          r_pass      <= 1'b0;
        end
        S_LOAD: begin
          r_op      <= w_load_op;
          r_exp_re  <= w_p_rr - w_p_ii;
          r_exp_im  <= w_p_ri + w_p_ir;
          r_tmo_cnt <= '0;
          if (r_mode[0]) r_lfsr <= w_lfsr_next;
        end
        S_DRIVE:    r_tmo_cnt <= op_ready ? 10'd0 : r_tmo_cnt + 10'd1;
        S_WAIT_RES: if (res_val) begin
          r_res_re <= res_re;
          r_res_im <= res_im;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 10'd1;
        end
        S_CHECK:    r_txn_done <= w_txn_next;
        default:    ;
      endcase
      if (r_state != S_IDLE) begin
        r_err_count <= w_err_next;
        r_timeout   <= w_timeout_next;
      end
      // Verdict is registered on the way into FINISH so it is visible during the done cycle and held after.
      if ((w_state_next == S_FINISH) && (r_state != S_FINISH))
        r_pass <= (w_err_next == 8'd0) && !w_timeout_next;
    end
  end

  assign sw_rst    = (r_state == S_SWRST);
  assign op_val    = (r_state == S_DRIVE);
  assign res_ready = (r_state == S_WAIT_RES);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FINISH);
  assign pass      = r_pass;
  assign timeout   = r_timeout;
  assign err_count = r_err_count;
  assign txn_done  = r_txn_done;
  assign op_1_re   = r_op[0];
  assign op_1_im   = r_op[1];
  assign op_2_re   = r_op[2];
  assign op_2_im   = r_op[3];
endmodule
